exec_datapath: RTL and testbench

Execute/memory slice of the 8-bit ExceptioNull CPU. It holds the instruction decoder (control_unit function), the 8-bit ALU (alu function) and a 256×8 data memory (data_memory function). It accepts one instruction per `instr_valid` pulse together with the register operands read by the CPU. One cycle later it returns the register write-back request and the next PC. The register file and PC register stay in the CPU top level.

---
 rtl/exec_datapath.sv | 180 ++++++++++++++++++
 tb/tb_exec_datapath.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_datapath.sv
// exec_datapath: execute/memory slice of the 8-bit ExceptioNull CPU.
// Decodes one instruction, runs the ALU, accesses a 256x8 data memory and
// returns a registered write-back request plus the next PC one cycle later.
// Optional build macro: DMEM_CLEAR_ON_RESET_EN clears every memory word at
// each reset edge; without it memory contents persist across reset.
//
// Handshake: there is no backpressure. An instruction is accepted on every
// rising edge where instr_valid=1 and rst_n=1; exactly one cycle later done
// pulses high for one cycle and the registered results belong to it. Back-to-
// back acceptance every cycle is allowed.
module exec_datapath (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [7:0] instruction,
    input  logic [7:0] pc,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] offset,
    output logic [1:0] reg_addr_0,
    output logic [1:0] reg_addr_1,
    output logic       done,
    output logic       wb_en,
    output logic [1:0] wb_addr,
    output logic [7:0] wb_data,
    output logic       overflow,
    output logic       branch,
    output logic [7:0] next_pc
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_ADDI = 4'b1000;
    localparam logic [3:0] OP_LW   = 4'b1001;
    localparam logic [3:0] OP_SW   = 4'b1010;
    localparam logic [3:0] OP_NOP  = 4'b1011;
    localparam logic [3:0] OP_BEQ  = 4'b1100;
    localparam logic [3:0] OP_BNE  = 4'b1101;
    localparam logic [3:0] OP_J    = 4'b1110;
    localparam logic [3:0] OP_JAL  = 4'b1111;

    logic [3:0] opcode;
    logic [7:0] mem_q [0:255];

    logic       done_q, wb_en_q, wb_en_d, overflow_q, overflow_d;
    logic       branch_q, branch_d;
    logic [1:0] wb_addr_q, wb_addr_d;
    logic [7:0] wb_data_q, wb_data_d, next_pc_q, next_pc_d;

    logic [7:0] pc_inc, add_res, sub_res, addi_res;
    logic       ops_equal;

    assign opcode     = instruction[7:4];
    assign reg_addr_0 = instruction[3:2];
    assign reg_addr_1 = instruction[1:0];

    assign pc_inc    = pc + 8'd1;
    assign add_res   = in0 + in1;
    assign sub_res   = in0 - in1;
    assign addi_res  = in0 + {6'b000000, instruction[1:0]};
    assign ops_equal = (in0 == in1);

    // Decode and execute: compute the next value of every registered result.
    always_comb begin
        wb_en_d    = 1'b0;
        wb_addr_d  = instruction[3:2];
        wb_data_d  = 8'h00;
        overflow_d = 1'b0;
        branch_d   = 1'b0;
        next_pc_d  = pc_inc;
        case (opcode)
            OP_ADD: begin
                wb_en_d    = 1'b1;
                wb_data_d  = add_res;
                overflow_d = (in0[7] == in1[7]) && (add_res[7] != in0[7]);
            end
            OP_SUB: begin
                wb_en_d    = 1'b1;
                wb_data_d  = sub_res;
                // rB sign inverted: overflow when signs differ and result flips.
                overflow_d = (in0[7] != in1[7]) && (sub_res[7] != in0[7]);
            end
            OP_AND: begin wb_en_d = 1'b1; wb_data_d = in0 & in1; end
            OP_OR:  begin wb_en_d = 1'b1; wb_data_d = in0 | in1; end
            OP_XOR: begin wb_en_d = 1'b1; wb_data_d = in0 ^ in1; end
            OP_SLT: begin
                wb_en_d   = 1'b1;
                wb_data_d = {7'b0000000, ($signed(in0) < $signed(in1))};
            end
            OP_SLL: begin wb_en_d = 1'b1; wb_data_d = in0 << in1[2:0]; end
            OP_SRL: begin wb_en_d = 1'b1; wb_data_d = in0 >> in1[2:0]; end
            OP_ADDI: begin
                wb_en_d    = 1'b1;
                wb_data_d  = addi_res;
                // Immediate is always non-negative, so only a positive rA can overflow.
                overflow_d = !in0[7] && addi_res[7];
            end
            OP_LW: begin
                wb_en_d   = 1'b1;
                // Memory array already holds any store accepted on the previous edge.
                wb_data_d = mem_q[in1];
            end
            OP_SW, OP_NOP: begin
            end
            OP_BEQ: begin
                branch_d = ops_equal;
                if (ops_equal) next_pc_d = pc_inc + offset;
            end
            OP_BNE: begin
                branch_d = !ops_equal;
                if (!ops_equal) next_pc_d = pc_inc + offset;
            end
            OP_J: next_pc_d = in0;
            OP_JAL: begin
                wb_en_d   = 1'b1;
                wb_addr_d = 2'd3;
                wb_data_d = pc_inc;
                next_pc_d = in0;
            end
            default: begin
            end
        endcase
    end

    // Result registers: pulses clear when idle, data fields hold their value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q     <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= 2'd0;
            wb_data_q  <= 8'h00;
            overflow_q <= 1'b0;
            branch_q   <= 1'b0;
            next_pc_q  <= 8'h00;
        end else begin
            done_q <= instr_valid;
            if (instr_valid) begin
                wb_en_q    <= wb_en_d;
                wb_addr_q  <= wb_addr_d;
                wb_data_q  <= wb_data_d;
                overflow_q <= overflow_d;
                branch_q   <= branch_d;
                next_pc_q  <= next_pc_d;
            end else begin
                wb_en_q  <= 1'b0;
                branch_q <= 1'b0;
            end
        end
    end

    // Data memory write port: stores land on the accepting edge, never in reset.
    always_ff @(posedge clk) begin
`ifdef DMEM_CLEAR_ON_RESET_EN
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem_q[i] <= 8'h00;
        end else if (instr_valid && (opcode == OP_SW)) begin
            mem_q[in1] <= in0;
        end
`else
        if (rst_n && instr_valid && (opcode == OP_SW)) begin
            mem_q[in1] <= in0;
        end
`endif
    end

    assign done     = done_q;
    assign wb_en    = wb_en_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;
    assign overflow = overflow_q;
    assign branch   = branch_q;
    assign next_pc  = next_pc_q;

endmodule

// File: tb/tb_exec_datapath.sv
// Testbench for exec_datapath: directed cases plus randomized instruction
// streams, checked against an arithmetic reference model of the CPU slice.
module tb_exec_datapath;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic [7:0] instruction, pc, in0, in1, offset;
    logic [1:0] reg_addr_0, reg_addr_1;
    logic       done, wb_en, overflow, branch;
    logic [1:0] wb_addr;
    logic [7:0] wb_data, next_pc;

    exec_datapath dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid),
        .instruction(instruction), .pc(pc), .in0(in0), .in1(in1),
        .offset(offset), .reg_addr_0(reg_addr_0), .reg_addr_1(reg_addr_1),
        .done(done), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .overflow(overflow), .branch(branch), .next_pc(next_pc)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic       done;
        logic       wd_known;
        logic       wb_en;
        logic       branch;
        logic       ovf;
        logic [1:0] wb_addr;
        logic [7:0] wb_data;
        logic [7:0] npc;
    } exp_t;
    localparam int W = $bits(exp_t);

    logic [W-1:0] exp_q[$];
    exp_t         last_exp;
    logic [7:0]   ref_mem [0:255];
    int           n_vectors = 0;
    int           n_miscompares = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int to_signed(input logic [7:0] v);
        return (v >= 8'd128) ? int'(v) - 256 : int'(v);
    endfunction

    // Reference model: opcode semantics expressed with integer arithmetic.
    function automatic exp_t ref_exec(input logic [7:0] ins, input logic [7:0] pcv,
                                      input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] off);
        exp_t e;
        int   sa, sb, r;
        int   op;
        op = int'(ins[7:4]);
        sa = to_signed(a);
        sb = to_signed(b);
        e = '0;
        e.done     = 1'b1;
        e.wd_known = 1'b1;
        e.wb_addr  = ins[3:2];
        e.npc      = 8'((int'(pcv) + 1) % 256);
        e.wb_en    = (op <= 9) || (op == 15);
        r = 0;
        case (op)
            0: begin r = sa + sb; e.ovf = (r > 127) || (r < -128); e.wb_data = r[7:0]; end
            1: begin r = sa - sb; e.ovf = (r > 127) || (r < -128); e.wb_data = r[7:0]; end
            2: e.wb_data = a & b;
            3: e.wb_data = a | b;
            4: e.wb_data = a ^ b;
            5: e.wb_data = (sa < sb) ? 8'd1 : 8'd0;
            6: begin r = (int'(a) * (1 << int'(b[2:0]))) % 256; e.wb_data = r[7:0]; end
            7: begin r = int'(a) / (1 << int'(b[2:0])); e.wb_data = r[7:0]; end
            8: begin r = sa + int'(ins[1:0]); e.ovf = (r > 127); e.wb_data = r[7:0]; end
            9: e.wb_data = ref_mem[b];
            12: begin
                e.wd_known = 1'b0;
                if (a == b) begin
                    e.branch = 1'b1;
                    e.npc = 8'((int'(pcv) + 1 + int'(off)) % 256);
                end
            end
            13: begin
                e.wd_known = 1'b0;
                if (a != b) begin
                    e.branch = 1'b1;
                    e.npc = 8'((int'(pcv) + 1 + int'(off)) % 256);
                end
            end
            14: begin e.wd_known = 1'b0; e.npc = a; end
            15: begin e.npc = a; e.wb_addr = 2'd3; e.wb_data = 8'((int'(pcv) + 1) % 256); end
            default: e.wd_known = 1'b0;
        endcase
        return e;
    endfunction

    task automatic compare_outputs();
        exp_t e;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 8'd1, 8'd0);
            return;
        end
        e = exp_q.pop_front();
        check("done",     {7'b0, done},     {7'b0, e.done});
        check("wb_en",    {7'b0, wb_en},    {7'b0, e.wb_en});
        check("branch",   {7'b0, branch},   {7'b0, e.branch});
        check("overflow", {7'b0, overflow}, {7'b0, e.ovf});
        check("wb_addr",  {6'b0, wb_addr},  {6'b0, e.wb_addr});
        check("next_pc",  next_pc,          e.npc);
        if (e.wd_known) check("wb_data", wb_data, e.wd_known ? e.wb_data : 8'h00);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [7:0] ins, input logic [7:0] pcv,
                         input logic [7:0] a, input logic [7:0] b, input logic [7:0] off);
        exp_t e;
        @(negedge clk);
        instr_valid = v;
        instruction = ins;
        pc          = pcv;
        in0         = a;
        in1         = b;
        offset      = off;
        #1;
        check("reg_addr_0", {6'b0, reg_addr_0}, {6'b0, ins[3:2]});
        check("reg_addr_1", {6'b0, reg_addr_1}, {6'b0, ins[1:0]});
        if (!rst_n) begin
            e = '0;
            e.wd_known = 1'b1;
`ifdef DMEM_CLEAR_ON_RESET_EN
            for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
`endif
        end else if (!v) begin
            e = last_exp;
            e.done   = 1'b0;
            e.wb_en  = 1'b0;
            e.branch = 1'b0;
        end else begin
            e = ref_exec(ins, pcv, a, b, off);
            if (ins[7:4] == 4'b1010) ref_mem[b] = a;
        end
        exp_q.push_back(e);
        last_exp = e;
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        // A store presented during reset must not reach memory.
        repeat (2) drive(1'b1, {4'b1010, 4'($urandom_range(0, 15))}, 8'($urandom),
                         8'($urandom), 8'($urandom), 8'($urandom));
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] mk(input logic [3:0] op, input logic [1:0] fa,
                                      input logic [1:0] fb);
        return {op, fa, fb};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] a, b, ins;
        int r;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instruction = 8'h00;
        pc = 8'h00; in0 = 8'h00; in1 = 8'h00; offset = 8'h00;
        last_exp = '0;

        do_reset();

        // Fill every memory word so later loads never see power-up X.
        for (int i = 0; i < 256; i++)
            drive(1'b1, mk(4'b1010, 2'd0, 2'd0), 8'(i), 8'($urandom), 8'(i), 8'h00);

        // Directed cases with absolute expected values.
        drive(1'b1, mk(4'b0000, 2'd1, 2'd2), 8'h00, 8'h7F, 8'h01, 8'h00);
        check("plan_add_data", wb_data, 8'h80);
        check("plan_add_ovf", {7'b0, overflow}, 8'h01);
        drive(1'b1, mk(4'b1010, 2'd0, 2'd1), 8'h01, 8'h5A, 8'h10, 8'h00);
        drive(1'b1, mk(4'b1001, 2'd2, 2'd1), 8'h02, 8'h00, 8'h10, 8'h00);
        check("plan_lw_data", wb_data, 8'h5A);
        drive(1'b1, mk(4'b1100, 2'd0, 2'd1), 8'h20, 8'h33, 8'h33, 8'h04);
        check("plan_beq_pc", next_pc, 8'h25);
        drive(1'b1, mk(4'b1101, 2'd0, 2'd1), 8'h20, 8'h33, 8'h33, 8'h04);
        check("plan_bne_pc", next_pc, 8'h21);
        drive(1'b1, mk(4'b1111, 2'd1, 2'd0), 8'h40, 8'h80, 8'h00, 8'h00);
        check("plan_jal_pc", next_pc, 8'h80);
        check("plan_jal_data", wb_data, 8'h41);
        drive(1'b1, mk(4'b0110, 2'd0, 2'd1), 8'h00, 8'h81, 8'h01, 8'h00);
        check("plan_sll_data", wb_data, 8'h02);
        drive(1'b1, mk(4'b0101, 2'd0, 2'd1), 8'h00, 8'hFF, 8'h01, 8'h00);
        check("plan_slt_data", wb_data, 8'h01);
        drive(1'b0, mk(4'b1010, 2'd0, 2'd1), 8'h00, 8'hEE, 8'h10, 8'h00);
        drive(1'b1, mk(4'b1001, 2'd0, 2'd1), 8'h00, 8'h00, 8'h10, 8'h00);
        check("idle_sw_no_write", wb_data, 8'h5A);

        // Randomized stream: idle gaps, resets, equal operands for branches.
        for (int n = 0; n < 700; n++) begin
            r   = $urandom_range(0, 99);
            ins = 8'($urandom);
            a   = 8'($urandom);
            b   = ($urandom_range(0, 2) == 0) ? a : 8'($urandom);
            if (r < 2) begin
                do_reset();
            end else if (r < 20) begin
                drive(1'b0, ins, 8'($urandom), a, b, 8'($urandom));
            end else begin
                drive(1'b1, ins, 8'($urandom), a, b, 8'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
